adc_conv_scheduler: RTL

Shares the single serial-ADC front end (12-bit SPI-style deserializer with CSn/SCLK/SDATA) between up to NUM_REQ on-chip requesters. It arbitrates pending requests round-robin and issues one conversion-start pulse per grant. It waits for the front end's completion strobe, or for a timeout, and returns the sample to the granted requester with a one-cycle acknowledge. It sits between the front end and the consumers (DAC path, monitors), in the Clk domain.

---
 rtl/adc_conv_scheduler_if.sv | 28 ++
 rtl/adc_conv_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler_if.sv
// Request/response and front-end handshake bundle for the ADC conversion scheduler.
// master: the scheduler itself; slave: requesters and serial front end.
interface adc_conv_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 12
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    REQ;
  logic [NUM_REQ-1:0]    ACK;
  logic [DATA_WIDTH-1:0] SAMPLE;
  logic                  ERR;
  logic [IdW-1:0]        GRANT_ID;
  logic                  BUSY;
  logic                  CONV_START;
  logic                  CONV_DONE;
  logic [DATA_WIDTH-1:0] CONV_DATA;

  modport master (
    input  REQ, CONV_DONE, CONV_DATA,
    output ACK, SAMPLE, ERR, GRANT_ID, BUSY, CONV_START
  );

  modport slave (
    output REQ, CONV_DONE, CONV_DATA,
    input  ACK, SAMPLE, ERR, GRANT_ID, BUSY, CONV_START
  );
endinterface

// File: rtl/adc_conv_scheduler.sv
// Round-robin scheduler sharing one serial-ADC front end between NUM_REQ requesters.
// One conversion per grant, bounded by a timeout, followed by an enforced idle gap.
module adc_conv_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MIN_GAP        = 4
) (
  input logic                  Clk,
  input logic                  Rst,
  adc_conv_scheduler_if.master bus
);
  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW = $clog2(MIN_GAP + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [IdW-1:0]        last_q, last_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  err_q, err_d;

  logic                  pick_valid;
  logic [IdW-1:0]        pick_id;
  logic [IdW-1:0]        idx;

  // Search starts one past the last served requester and wraps, so the first hit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdW'((32'(last_q) + i) % NUM_REQ);
      if (!pick_valid && bus.REQ[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sample_d  = sample_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_id;
          state_d = StStart;
        end
      end
      StStart: begin
        to_cnt_d = ToW'(TIMEOUT_CYCLES);
        state_d  = StWait;
      end
      StWait: begin
        // A completion on the expiry cycle still delivers real data.
        if (bus.CONV_DONE) begin
          sample_d = bus.CONV_DATA;
          err_d    = 1'b0;
          state_d  = StResp;
        end else if (to_cnt_q == ToW'(1)) begin
          sample_d = '0;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          to_cnt_d = to_cnt_q - ToW'(1);
        end
      end
      StResp: begin
        last_d    = grant_q;
        gap_cnt_d = GapW'(MIN_GAP);
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapW'(1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IdW'(NUM_REQ - 1);
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      sample_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sample_q  <= sample_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    bus.ACK = '0;
    if (state_q == StResp) begin
      bus.ACK[grant_q] = 1'b1;
    end
  end

  assign bus.SAMPLE     = sample_q;
  assign bus.ERR        = err_q;
  assign bus.GRANT_ID   = grant_q;
  assign bus.BUSY       = (state_q != StIdle);
  assign bus.CONV_START = (state_q == StStart);

endmodule
